// File: rtl/battlechip_pkg.sv
// Shared constants and types for the battlechip targeting blocks.
//   BOARD_DIM / NUM_CELLS : board geometry (10x10, 100 cells)
//   DENS_W                : width of one density-map entry
//   dens_t, cell_idx_t, coord_t : common datapath types
//   ts_state_e            : target-select controller states
package battlechip_pkg;

  localparam int BOARD_DIM = 10;
  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam int DENS_W    = 6;

  typedef logic [DENS_W-1:0] dens_t;
  typedef logic [6:0]        cell_idx_t;
  typedef logic [3:0]        coord_t;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_SCAN = 2'd1,
    TS_DONE = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ai_target_select.sv
// Picks the next shot: the unfired cell with the highest density in the
// AI's placement-density map. Inputs are snapshotted at start so the AI can
// recompute while the scan runs; one cell is examined per clock.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   request a selection (only honoured in IDLE)
//   density      in   per-cell density, cell index = row*10+col
//   fired        in   1 = cell already shot
//   busy         out  high while scanning
//   done         out  one-cycle pulse, result valid from this cycle on
//   target_valid out  an unfired cell was found
//   target_idx   out  selected cell index
//   target_row   out  selected row
//   target_col   out  selected column
//   target_dens  out  density of the selected cell
//
// state   | meaning
// --------+-----------------------------------------------------------
// TS_IDLE | waiting for start; outputs hold the previous result
// TS_SCAN | examining snapshot cell scan_idx_q, updating best-so-far
// TS_DONE | publishing best-so-far, pulsing done, back to IDLE
module ai_target_select
  import battlechip_pkg::cell_idx_t, battlechip_pkg::coord_t,
         battlechip_pkg::ts_state_e, battlechip_pkg::TS_IDLE,
         battlechip_pkg::TS_SCAN, battlechip_pkg::TS_DONE;
#(
  parameter int         BOARD_DIM  = 10,
  parameter int         DENS_W     = 6,
  parameter int         TIE_RANDOM = 0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [BOARD_DIM*BOARD_DIM-1:0][DENS_W-1:0] density,
  input  logic [BOARD_DIM*BOARD_DIM-1:0]              fired,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        target_valid,
  output logic [6:0]                                  target_idx,
  output logic [3:0]                                  target_row,
  output logic [3:0]                                  target_col,
  output logic [DENS_W-1:0]                           target_dens
);

  localparam int        NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam cell_idx_t LAST_IDX  = cell_idx_t'(NUM_CELLS - 1);
  localparam coord_t    LAST_COL  = coord_t'(BOARD_DIM - 1);

  ts_state_e state_q;

  logic [NUM_CELLS-1:0][DENS_W-1:0] snap_dens_q;
  logic [NUM_CELLS-1:0]             snap_fired_q;

  cell_idx_t scan_idx_q;
  coord_t    row_q, col_q;

  logic              best_valid_q;
  logic [DENS_W-1:0] best_dens_q;
  cell_idx_t         best_idx_q;
  coord_t            best_row_q, best_col_q;

  logic [7:0] lfsr_q, lfsr_d;

  logic              busy_q, done_q, target_valid_q;
  cell_idx_t         target_idx_q;
  coord_t            target_row_q, target_col_q;
  logic [DENS_W-1:0] target_dens_q;

  logic [DENS_W-1:0] cur_dens;
  logic              cand;
  logic              replace;

  // x^8+x^6+x^5+x^4+1, Fibonacci form, free-running
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    cur_dens = snap_dens_q[scan_idx_q];
    cand     = ~snap_fired_q[scan_idx_q];
    replace  = cand && (!best_valid_q || (cur_dens > best_dens_q) ||
               ((TIE_RANDOM != 0) && (cur_dens == best_dens_q) && lfsr_q[0]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= TS_IDLE;
      snap_dens_q    <= '0;
      snap_fired_q   <= '0;
      scan_idx_q     <= '0;
      row_q          <= '0;
      col_q          <= '0;
      best_valid_q   <= 1'b0;
      best_dens_q    <= '0;
      best_idx_q     <= '0;
      best_row_q     <= '0;
      best_col_q     <= '0;
      lfsr_q         <= LFSR_SEED;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      target_valid_q <= 1'b0;
      target_idx_q   <= '0;
      target_row_q   <= '0;
      target_col_q   <= '0;
      target_dens_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      done_q <= 1'b0;
      unique case (state_q)
        TS_IDLE: begin
          if (start) begin
            snap_dens_q  <= density;
            snap_fired_q <= fired;
            best_valid_q <= 1'b0;
            best_dens_q  <= '0;
            best_idx_q   <= '0;
            best_row_q   <= '0;
            best_col_q   <= '0;
            scan_idx_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= TS_SCAN;
          end
        end
        TS_SCAN: begin
          if (replace) begin
            best_valid_q <= 1'b1;
            best_dens_q  <= cur_dens;
            best_idx_q   <= scan_idx_q;
            best_row_q   <= row_q;
            best_col_q   <= col_q;
          end
          if (scan_idx_q == LAST_IDX) begin
            state_q <= TS_DONE;
          end else begin
            scan_idx_q <= scan_idx_q + 7'd1;
            // row/col follow the index so the result needs no divider
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 4'd1;
            end else begin
              col_q <= col_q + 4'd1;
            end
          end
        end
        TS_DONE: begin
          done_q         <= 1'b1;
          busy_q         <= 1'b0;
          target_valid_q <= best_valid_q;
          target_idx_q   <= best_valid_q ? best_idx_q  : '0;
          target_row_q   <= best_valid_q ? best_row_q  : '0;
          target_col_q   <= best_valid_q ? best_col_q  : '0;
          target_dens_q  <= best_valid_q ? best_dens_q : '0;
          state_q        <= TS_IDLE;
        end
        default: state_q <= TS_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign target_valid = target_valid_q;
  assign target_idx   = target_idx_q;
  assign target_row   = target_row_q;
  assign target_col   = target_col_q;
  assign target_dens  = target_dens_q;

endmodule

// File: doc/ai_target_select.md
Name: ai_target_select

Overview:
- Consumer of the placement-density AI's output map.
- Given a 100-cell density map (6 bits per cell) and the fired map, it sequentially scans all cells and selects the unfired cell with the highest density as the next shot.
- Sits between the density AI and the game/shot controller.
- Uses a start/busy/done handshake and snapshots its inputs at start, so the AI may recompute during the scan.

Parameters:
- BOARD_DIM, 10, board side length; number of cells is BOARD_DIM*BOARD_DIM.
- DENS_W, 6, width of one density entry.
- TIE_RANDOM, 0, 0 = on a density tie the lowest index wins; 1 = on a tie the candidate replaces the current best when lfsr[0]=1.
- LFSR_SEED, 8'hA5, reset value of the 8-bit tie-break LFSR (nonzero).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a selection; sampled only in IDLE.
- density  input  [99:0][DENS_W-1:0]  per-cell placement count from the AI; cell index = row*10+col.
- fired  input  100  1 = cell already shot.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse; result valid from this cycle on.
- target_valid  output  1  1 = an unfired cell was found.
- target_idx  output  7  selected cell index, 0..99.
- target_row  output  4  target_idx / 10.
- target_col  output  4  target_idx % 10.
- target_dens  output  DENS_W  density of the selected cell.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state to IDLE; busy=0, done=0, target_valid=0; target_idx/row/col/dens=0.
  - LFSR loads LFSR_SEED.
  - Reset during SCAN aborts the scan; no done is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge T: snapshot density and fired into internal registers.
  - Clear best_valid, best_dens and best_idx; scan index, row and col counters go to 0.
  - Go to SCAN; busy=1 from T+1.
- SCAN (cycles T+1..T+100), one cell per cycle, index k = cycle-T-1:
  - Candidate if snap_fired[k]==0.
  - Replace best if candidate and any of:
    - best_valid==0;
    - dens>best_dens;
    - dens==best_dens and TIE_RANDOM==1 and lfsr[0]==1.
  - Zero-density unfired cells are legal candidates.
  - Row/col are tracked with counters (col wraps 9->0 and increments row); no divider.
  - After k=99, go to DONE.
- DONE (cycle T+101):
  - done=1 and busy=0; outputs load from best registers; target_valid=best_valid.
  - If no candidate was found: target_valid=0 and idx/row/col/dens=0.
  - Go to IDLE next cycle.
  - Outputs hold until the next DONE or reset.
- Latency: start sampled at T gives done at T+101. Throughput: one selection per 102 cycles.
- start while busy or in DONE is ignored (not queued); start must be re-asserted in IDLE.
- start held high continuously restarts at each IDLE cycle.
- Input changes after T do not affect the result.
- LFSR (x^8+x^6+x^5+x^4+1) advances every cycle regardless of state.

Decomposition:
- battlechip_pkg:
  - constants BOARD_DIM=10, NUM_CELLS=100, DENS_W=6;
  - typedefs dens_t (logic [DENS_W-1:0]), cell_idx_t (logic [6:0]), coord_t (logic [3:0]);
  - state enum ts_state_e {TS_IDLE, TS_SCAN, TS_DONE}.
- Single module; the compare/update is small enough to stay inline. No sub-module.

Test Plan:
- fired=0, density all 0 except cell 57=6'd40, start pulse -> done exactly 101 cycles later; target_idx=57, row=5, col=7, dens=40, valid=1.
- fired=0, density all 6'd12, TIE_RANDOM=0 -> target_idx=0, dens=12. Then fired[0]=1 -> target_idx=1.
- density[99]=63 with fired[99]=1, density[98]=62 -> target_idx=98, row=9, col=8, dens=62.
- fired all 1s -> done after 101 cycles with target_valid=0, target_idx=0. Also density all 0 with fired[42]=0 only -> idx 42, dens 0, valid=1.
- Mid-scan input change: start with max at cell 10 (dens 30); change density[20]=63 at T+5 -> result remains 10. start pulses during busy are ignored, and done pulses once.
- rst_n=0 at T+50 of a scan -> no done, all outputs 0, state IDLE. A new start then gives a correct result after 101 cycles.
